// File: rtl/exec_mem_unit.sv
// Execute/memory unit: ALU, branch resolver and byte-addressable data memory.
// Ports: clk, rst (async active-low); a, b, alu_op -> alu_o;
//   op_code, br_type, rs1_data, rs2_data -> br_en;
//   addr, wr_data, mem_wr, mem_rd, mask -> dmem_o (combinational load).
// Optional feature macro: EXEC_MEM_MUL_EN enables MUL on alu_op 11.
module exec_mem_unit #(
   parameter int DMEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  alu_op,
   output logic [31:0] alu_o,
   input  logic [6:0]  op_code,
   input  logic [2:0]  br_type,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic        br_en,
   input  logic [31:0] addr,
   input  logic [31:0] wr_data,
   input  logic        mem_wr,
   input  logic        mem_rd,
   input  logic [2:0]  mask,
   output logic [31:0] dmem_o
);

   localparam int AW = $clog2(DMEM_WORDS);

   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_BR   = 7'b1100011;

   // ---------------- ALU ----------------
   logic [4:0] shamt;
   assign shamt = b[4:0];

   always_comb begin
      alu_o = '0;
      case (alu_op)
         4'd0:  alu_o = a + b;
         4'd1:  alu_o = a - b;
         4'd2:  alu_o = a << shamt;
         4'd3:  alu_o = {31'd0, $signed(a) < $signed(b)};
         4'd4:  alu_o = {31'd0, a < b};
         4'd5:  alu_o = a ^ b;
         4'd6:  alu_o = a >> shamt;
         4'd7:  alu_o = $unsigned($signed(a) >>> shamt);
         4'd8:  alu_o = a | b;
         4'd9:  alu_o = a & b;
         4'd10: alu_o = b;
`ifdef EXEC_MEM_MUL_EN
         4'd11: alu_o = a * b;
`else
         4'd11: alu_o = '0;
`endif
         default: alu_o = '0;
      endcase
   end

   // ---------------- Branch ----------------
   logic br_eq;
   logic br_lt;
   logic br_ltu;
   assign br_eq  = (rs1_data == rs2_data);
   assign br_lt  = ($signed(rs1_data) < $signed(rs2_data));
   assign br_ltu = (rs1_data < rs2_data);

   always_comb begin
      br_en = 1'b0;
      case (op_code)
         OP_JAL, OP_JALR: br_en = 1'b1;
         OP_BR: begin
            case (br_type)
               3'b000:  br_en = br_eq;
               3'b001:  br_en = !br_eq;
               3'b100:  br_en = br_lt;
               3'b101:  br_en = !br_lt;
               3'b110:  br_en = br_ltu;
               3'b111:  br_en = !br_ltu;
               default: br_en = 1'b0;
            endcase
         end
         default: br_en = 1'b0;
      endcase
   end

   // ---------------- Data memory ----------------
   logic [31:0]   mem_q [DMEM_WORDS];
   logic [AW-1:0] idx;
   logic [31:0]   rword;
   logic [7:0]    rbyte;
   logic [15:0]   rhalf;

   assign idx   = addr[AW+1:2];
   assign rword = mem_q[idx];
   assign rbyte = rword[8*addr[1:0] +: 8];
   assign rhalf = addr[1] ? rword[31:16] : rword[15:0];

   // Upper address bits deliberately ignored so addresses wrap.
   logic unused_addr;
   assign unused_addr = ^addr[31:AW+2];

   always_comb begin
      dmem_o = '0;
      if (mem_rd) begin
         case (mask)
            3'b000:  dmem_o = {{24{rbyte[7]}}, rbyte};
            3'b100:  dmem_o = {24'd0, rbyte};
            3'b001:  dmem_o = {{16{rhalf[15]}}, rhalf};
            3'b101:  dmem_o = {16'd0, rhalf};
            3'b010:  dmem_o = rword;
            default: dmem_o = '0;
         endcase
      end
   end

   // Store lanes: data replicated across lanes, byte-enables pick the lane.
   logic [3:0]  be_d;
   logic [31:0] wd_d;

   always_comb begin
      be_d = 4'b0000;
      wd_d = wr_data;
      if (mem_wr) begin
         case (mask)
            3'b000, 3'b100: begin
               be_d = 4'b0001 << addr[1:0];
               wd_d = {4{wr_data[7:0]}};
            end
            3'b001, 3'b101: begin
               be_d = addr[1] ? 4'b1100 : 4'b0011;
               wd_d = {2{wr_data[15:0]}};
            end
            3'b010:  be_d = 4'b1111;
            default: be_d = 4'b0000;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DMEM_WORDS; i++) mem_q[i] <= '0;
      end else begin
         for (int k = 0; k < 4; k++)
            if (be_d[k]) mem_q[idx][8*k +: 8] <= wd_d[8*k +: 8];
      end
   end

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed self-checking bench for exec_mem_unit.
// Checks ALU, branch, load/store lanes, aliasing and async reset.
module tb_exec_mem_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a, b;
   logic [3:0]  alu_op;
   logic [31:0] alu_o;
   logic [6:0]  op_code;
   logic [2:0]  br_type;
   logic [31:0] rs1_data, rs2_data;
   logic        br_en;
   logic [31:0] addr, wr_data;
   logic        mem_wr, mem_rd;
   logic [2:0]  mask;
   logic [31:0] dmem_o;

   int n_assert = 0;
   int n_fail   = 0;

   exec_mem_unit #(.DMEM_WORDS(256)) dut (
      .clk(clk), .rst(rst),
      .a(a), .b(b), .alu_op(alu_op), .alu_o(alu_o),
      .op_code(op_code), .br_type(br_type),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .br_en(br_en),
      .addr(addr), .wr_data(wr_data),
      .mem_wr(mem_wr), .mem_rd(mem_rd), .mask(mask),
      .dmem_o(dmem_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic alu(input logic [3:0] op, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] exp,
                      input string tag);
      alu_op = op; a = x; b = y;
      #1;
      chk(tag, alu_o, exp);
   endtask

   task automatic br(input logic [6:0] oc, input logic [2:0] bt,
                     input logic [31:0] r1, input logic [31:0] r2,
                     input logic exp, input string tag);
      op_code = oc; br_type = bt; rs1_data = r1; rs2_data = r2;
      #1;
      chk(tag, {31'd0, br_en}, {31'd0, exp});
   endtask

   task automatic store(input logic [31:0] ad, input logic [31:0] d,
                        input logic [2:0] m);
      @(negedge clk);
      addr = ad; wr_data = d; mask = m; mem_wr = 1'b1; mem_rd = 1'b0;
      @(posedge clk); #1;
      mem_wr = 1'b0;
   endtask

   task automatic load(input logic [31:0] ad, input logic [2:0] m,
                       input logic [31:0] exp, input string tag);
      addr = ad; mask = m; mem_rd = 1'b1; mem_wr = 1'b0;
      #1;
      chk(tag, dmem_o, exp);
   endtask

   initial begin
      rst = 1'b0;
      a = 0; b = 0; alu_op = 0;
      op_code = 0; br_type = 0; rs1_data = 0; rs2_data = 0;
      addr = 0; wr_data = 0; mem_wr = 0; mem_rd = 0; mask = 0;

      // Reset state and reset independence of ALU
      #2;
      load(32'h10, 3'b010, 32'h0, "reset_read");
      alu(4'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, "add_in_reset");
      @(negedge clk);
      rst = 1'b1;

      // ALU
      alu(4'd1, 32'h0, 32'd1, 32'hFFFFFFFF, "sub_wrap");
      alu(4'd7, 32'h80000000, 32'd4, 32'hF8000000, "sra");
      alu(4'd6, 32'h80000000, 32'd4, 32'h08000000, "srl");
      alu(4'd3, 32'h80000000, 32'd1, 32'd1, "slt");
      alu(4'd4, 32'h80000000, 32'd1, 32'd0, "sltu");
      alu(4'd2, 32'h00000001, 32'h00000024, 32'h00000010, "sll_shamt");
      alu(4'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, "xor");
      alu(4'd8, 32'hF0F00000, 32'h0000000F, 32'hF0F0000F, "or");
      alu(4'd9, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, "and");
      alu(4'd10, 32'h12345678, 32'hABCDE000, 32'hABCDE000, "lui");
      alu(4'd12, 32'h12345678, 32'h1, 32'h0, "op12");
      alu(4'd15, 32'h12345678, 32'h1, 32'h0, "op15");
`ifdef EXEC_MEM_MUL_EN
      alu(4'd11, 32'd3, 32'd5, 32'd15, "mul");
`else
      alu(4'd11, 32'd3, 32'd5, 32'd0, "mul_off");
`endif

      // Branch
      br(7'b1100011, 3'b100, 32'hFFFFFFFF, 32'd1, 1'b1, "blt");
      br(7'b1100011, 3'b110, 32'hFFFFFFFF, 32'd1, 1'b0, "bltu");
      br(7'b1100011, 3'b101, 32'hFFFFFFFF, 32'd1, 1'b0, "bge");
      br(7'b1100011, 3'b111, 32'hFFFFFFFF, 32'd1, 1'b1, "bgeu");
      br(7'b1100011, 3'b000, 32'd7, 32'd7, 1'b1, "beq");
      br(7'b1100011, 3'b001, 32'd7, 32'd7, 1'b0, "bne");
      br(7'b1100011, 3'b010, 32'd7, 32'd7, 1'b0, "br010");
      br(7'b1100011, 3'b011, 32'd7, 32'd8, 1'b0, "br011");
      br(7'b1101111, 3'b010, 32'd0, 32'd1, 1'b1, "jal");
      br(7'b1100111, 3'b011, 32'd0, 32'd1, 1'b1, "jalr");
      br(7'b0110011, 3'b000, 32'd7, 32'd7, 1'b0, "rtype");

      // Loads after word store
      store(32'h10, 32'h80FF7F01, 3'b010);
      load(32'h10, 3'b010, 32'h80FF7F01, "ld_word");
      load(32'h13, 3'b000, 32'hFFFFFF80, "ld_byte_s");
      load(32'h13, 3'b100, 32'h00000080, "ld_byte_u");
      load(32'h12, 3'b001, 32'hFFFF80FF, "ld_half_s");
      load(32'h12, 3'b101, 32'h000080FF, "ld_half_u");
      load(32'h11, 3'b000, 32'h0000007F, "ld_byte1_s");
      load(32'h13, 3'b010, 32'h80FF7F01, "ld_word_mis");
      load(32'h13, 3'b101, 32'h000080FF, "ld_half_mis");
      load(32'h10, 3'b011, 32'h0, "ld_mask011");
      load(32'h10, 3'b110, 32'h0, "ld_mask110");
      load(32'h10, 3'b111, 32'h0, "ld_mask111");
      mem_rd = 1'b0; #1;
      chk("rd_off", dmem_o, 32'h0);
      load(32'h410, 3'b010, 32'h80FF7F01, "alias");

      // Byte/half store lanes
      store(32'h11, 32'h123456AB, 3'b011);
      load(32'h10, 3'b010, 32'h80FF7F01, "st_mask011");
      store(32'h11, 32'h123456AB, 3'b000);
      load(32'h10, 3'b010, 32'h80FFAB01, "st_byte");
      store(32'h12, 32'hCAFE1234, 3'b101);
      load(32'h10, 3'b010, 32'h1234AB01, "st_half_hi");
      store(32'h414, 32'hDEADBEEF, 3'b010);
      load(32'h14, 3'b010, 32'hDEADBEEF, "st_alias");
      load(32'h10, 3'b010, 32'h1234AB01, "st_neighbor");

      // Simultaneous read and write: old data until the edge
      @(negedge clk);
      addr = 32'h10; mask = 3'b010; wr_data = 32'h55AA55AA;
      mem_wr = 1'b1; mem_rd = 1'b1;
      #1;
      chk("rw_before", dmem_o, 32'h1234AB01);
      @(posedge clk); #1;
      chk("rw_after", dmem_o, 32'h55AA55AA);
      mem_wr = 1'b0;

      // Async reset mid-cycle, store blocked during reset
      @(negedge clk); #2;
      rst = 1'b0;
      #1;
      chk("rst_clear", dmem_o, 32'h0);
      addr = 32'h14; #1;
      chk("rst_clear2", dmem_o, 32'h0);
      addr = 32'h10; wr_data = 32'h11111111; mem_wr = 1'b1;
      @(posedge clk); #1;
      chk("rst_st_blocked", dmem_o, 32'h0);
      @(negedge clk);
      mem_wr = 1'b0;
      rst = 1'b1;
      #1;
      chk("post_rst", dmem_o, 32'h0);
      store(32'h10, 32'h00C0FFEE, 3'b010);
      load(32'h10, 3'b010, 32'h00C0FFEE, "post_rst_store");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
